// File: rtl/oscillation_monitor_if.sv
// Sample-side and result-side signals of the oscillation monitor.
// step_err exists only when STEP_CHECK_EN is defined.
interface oscillation_monitor_if #(
  parameter int COORD_W  = 7,
  parameter int PERIOD_W = 9,
  parameter int BOUNCE_W = 8
);
  logic                en;
  logic                clear;
  logic [COORD_W-1:0]  coord;
  logic                dir;
  logic                moving;
  logic                top_pulse;
  logic                bot_pulse;
  logic [COORD_W-1:0]  peak;
  logic [COORD_W-1:0]  valley;
  logic [BOUNCE_W-1:0] bounce_count;
  logic [PERIOD_W-1:0] period;
  logic                locked;
`ifdef STEP_CHECK_EN
  logic                step_err;
`endif

  modport master (
`ifdef STEP_CHECK_EN
    input  step_err,
`endif
    output en, clear, coord,
    input  dir, moving, top_pulse, bot_pulse,
    input  peak, valley, bounce_count, period, locked
  );

  modport slave (
`ifdef STEP_CHECK_EN
    output step_err,
`endif
    input  en, clear, coord,
    output dir, moving, top_pulse, bot_pulse,
    output peak, valley, bounce_count, period, locked
  );
endinterface

// File: rtl/oscillation_monitor.sv
// Recovers direction, turning points, bounce count and period from a
// bouncing coordinate stream. Optional STEP_CHECK_EN adds step_err.
module oscillation_monitor #(
  parameter int COORD_W  = 7,
  parameter int PERIOD_W = 9,
  parameter int BOUNCE_W = 8
) (
  input logic clk,
  input logic reset_n,
  oscillation_monitor_if.slave bus
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] ACQ  = 2'b01;
  localparam logic [1:0] UP   = 2'b10;
  localparam logic [1:0] DOWN = 2'b11;

  logic [1:0]          state, nxt;
  logic [COORD_W-1:0]  prev;
  logic [COORD_W-1:0]  peak_q, valley_q;
  logic [PERIOD_W-1:0] cnt, period_q;
  logic [BOUNCE_W-1:0] bc;
  logic                top_q, bot_q, lock_q;
  logic                inc, dec, step_bad;
  logic                peak_turn, valley_turn;
  logic [COORD_W-1:0]  delta;

  // Classify the current sample against the previous one
  always_comb begin
    inc   = bus.coord > prev;
    dec   = bus.coord < prev;
    delta = inc ? bus.coord - prev : prev - bus.coord;
    step_bad = 1'b0;
`ifdef STEP_CHECK_EN
    step_bad = (state != IDLE) && (delta[COORD_W-1:1] != '0);
`endif
    peak_turn   = (state == UP) && dec && !step_bad;
    valley_turn = (state == DOWN) && inc && !step_bad;
    nxt = state;
    case (state)
      IDLE: nxt = ACQ;
      ACQ: begin
        if (inc) nxt = UP;
        else if (dec) nxt = DOWN;
      end
      UP:   if (dec) nxt = DOWN;
      default: if (inc) nxt = UP;
    endcase
    if (step_bad) nxt = ACQ;
  end

`ifdef STEP_CHECK_EN
  logic err_q;

  // Sticky step error, cleared only by reset or clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else if (bus.clear) err_q <= 1'b0;
    else if (bus.en && step_bad) err_q <= 1'b1;
  end

  assign bus.step_err = err_q;
`endif

  // Tracker state, statistics and registered pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      prev     <= '0;
      cnt      <= '0;
      period_q <= '0;
      peak_q   <= '0;
      valley_q <= '0;
      bc       <= '0;
      top_q    <= 1'b0;
      bot_q    <= 1'b0;
      lock_q   <= 1'b0;
    end else if (bus.clear) begin
      state    <= IDLE;
      prev     <= '0;
      cnt      <= '0;
      period_q <= '0;
      peak_q   <= '0;
      valley_q <= '0;
      bc       <= '0;
      top_q    <= 1'b0;
      bot_q    <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      top_q <= 1'b0;
      bot_q <= 1'b0;
      if (bus.en) begin
        prev  <= bus.coord;
        state <= nxt;
        if (step_bad) begin
          lock_q <= 1'b0;
          cnt    <= '0;
        end else if (peak_turn) begin
          peak_q   <= prev;
          top_q    <= 1'b1;
          bc       <= bc + 1'b1;
          period_q <= cnt;
          cnt      <= {{(PERIOD_W-1){1'b0}}, 1'b1};
          lock_q   <= (cnt == period_q) && (prev == peak_q)
                      && (period_q != '0);
        end else begin
          if (valley_turn) begin
            valley_q <= prev;
            bot_q    <= 1'b1;
            bc       <= bc + 1'b1;
          end
          if (cnt != '0 && cnt != '1) cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.moving       = state[1];
  assign bus.dir          = state[1] & state[0];
  assign bus.top_pulse    = top_q;
  assign bus.bot_pulse    = bot_q;
  assign bus.peak         = peak_q;
  assign bus.valley       = valley_q;
  assign bus.bounce_count = bc;
  assign bus.period       = period_q;
  assign bus.locked       = lock_q;

endmodule

// File: tb/tb_oscillation_monitor.sv
// Scoreboard bench for oscillation_monitor: directed bounce streams,
// expected outputs queued per sample index and checked by a monitor.
module tb_oscillation_monitor;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  string tag = "init";

  oscillation_monitor_if bus ();

  oscillation_monitor dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [35:0] v;
  } exp_t;

  exp_t q[$];
  int   nsamp = 0;
  int   cur_i = 0;
  bit   cur_s = 1'b0;

  function automatic logic [35:0] act();
    return {bus.moving, bus.dir, bus.top_pulse, bus.bot_pulse,
            bus.peak, bus.valley, bus.bounce_count, bus.period,
            bus.locked};
  endfunction

  task automatic push(input int idx, input bit mv, input bit dr,
                      input bit tp, input bit bt, input int pk,
                      input int vl, input int bc, input int pd,
                      input bit lk);
    exp_t e;
    logic [6:0] p7, v7;
    logic [7:0] b8;
    logic [8:0] d9;
    p7 = 7'(pk);
    v7 = 7'(vl);
    b8 = 8'(bc);
    d9 = 9'(pd);
    e.idx = idx;
    e.v = {mv, dr, tp, bt, p7, v7, b8, d9, lk};
    q.push_back(e);
  endtask

  always @(negedge reset_n) nsamp = 0;

  always @(posedge clk) begin
    cur_s = reset_n && bus.en && !bus.clear;
    cur_i = nsamp;
    if (!reset_n || bus.clear) nsamp = 0;
    else if (bus.en) nsamp++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (cur_s) begin
        if (q.size() > 0 && q[0].idx == cur_i) begin
          e = q.pop_front();
          total++;
          if (act() !== e.v) begin
            bad++;
            $display("FAIL %s k%0d: got %h want %h",
                     tag, cur_i, act(), e.v);
          end
        end
      end else begin
        total++;
        if (bus.top_pulse !== 1'b0 || bus.bot_pulse !== 1'b0) begin
          bad++;
          $display("FAIL %s idle_pulse: got top=%b bot=%b want 0",
                   tag, bus.top_pulse, bus.bot_pulse);
        end
      end
    end
  end

  task automatic chk_zero(input string nm);
    total++;
    if (act() !== '0) begin
      bad++;
      $display("FAIL %s: got %h want 0", nm, act());
    end
  endtask

  task automatic drain(input string nm);
    repeat (2) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s drain: got %0d pending want 0", nm, q.size());
      q.delete();
    end
  endtask

  task automatic samp(input int c, input int gap);
    bus.coord = 7'(c);
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic ramp(input int a, input int b, input int gap);
    if (a <= b) for (int v = a; v <= b; v++) samp(v, gap);
    else for (int v = a; v >= b; v--) samp(v, gap);
  endtask

  task automatic bounce(input int l, input int u, input int n,
                        input int gap);
    repeat (n) begin
      ramp(l, u, gap);
      ramp(u, l, gap);
    end
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  task automatic push_base();
    push(0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    push(1,  1, 0, 0, 0, 0, 0, 0, 0, 0);
    push(5,  1, 1, 1, 0, 5, 0, 1, 0, 0);
    push(6,  1, 1, 0, 0, 5, 0, 1, 0, 0);
    push(9,  1, 0, 0, 1, 5, 2, 2, 0, 0);
    push(13, 1, 1, 1, 0, 5, 2, 3, 8, 0);
    push(17, 1, 0, 0, 1, 5, 2, 4, 8, 0);
    push(21, 1, 1, 1, 0, 5, 2, 5, 8, 1);
    push(22, 1, 1, 0, 0, 5, 2, 5, 8, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.en = 1'b0;
    bus.clear = 1'b0;
    bus.coord = '0;
    #12;
    chk_zero("reset_state");
    @(negedge clk);
    reset_n = 1'b1;

    tag = "full_rate";
    do_clear();
    push_base();
    push(25, 1, 0, 0, 1, 5, 2, 6, 8, 1);
    push(33, 1, 1, 1, 0, 9, 2, 7, 12, 0);
    push(49, 1, 1, 1, 0, 9, 2, 9, 16, 0);
    push(57, 1, 0, 0, 1, 9, 2, 10, 16, 0);
    push(65, 1, 1, 1, 0, 9, 2, 11, 16, 1);
    bounce(2, 5, 3, 0);
    bounce(2, 9, 3, 0);
    drain(tag);

    tag = "strobe_1of4";
    do_clear();
    push_base();
    bounce(2, 5, 3, 3);
    drain(tag);

    tag = "constant";
    do_clear();
    push(0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    push(10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    push(19, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (20) samp(40, 0);
    drain(tag);

    tag = "async_reset";
    do_clear();
    push(5, 1, 1, 1, 0, 5, 0, 1, 0, 0);
    ramp(2, 5, 0);
    ramp(5, 4, 0);
    drain(tag);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk_zero("async_reset_now");
    @(negedge clk);
    reset_n = 1'b1;

    tag = "clear_up";
    do_clear();
    push(9, 1, 0, 0, 1, 5, 2, 2, 0, 0);
    bounce(2, 5, 1, 0);
    ramp(2, 4, 0);
    drain(tag);
    bus.coord = 7'd5;
    bus.en = 1'b1;
    bus.clear = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    bus.clear = 1'b0;
    chk_zero("clear_mid_up");

`ifdef STEP_CHECK_EN
    tag = "step_check";
    do_clear();
    samp(10, 0);
    samp(11, 0);
    samp(12, 0);
    samp(20, 0);
    total++;
    if ({bus.step_err, bus.moving, bus.locked} !== 3'b100) begin
      bad++;
      $display("FAIL step_at_20: got %b want 100",
               {bus.step_err, bus.moving, bus.locked});
    end
    samp(21, 0);
    total++;
    if ({bus.step_err, bus.moving, bus.dir} !== 3'b110) begin
      bad++;
      $display("FAIL reacq_at_21: got %b want 110",
               {bus.step_err, bus.moving, bus.dir});
    end
    do_clear();
    total++;
    if (bus.step_err !== 1'b0) begin
      bad++;
      $display("FAIL step_clear: got %b want 0", bus.step_err);
    end
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oscillation_monitor.md
Name: oscillation_monitor

Overview:
- Consumer-side counterpart to the bouncing coordinate generator. It samples a 7-bit coordinate stream on an enable strobe and recovers the motion parameters.
- Recovered values: direction, turning points (peak/valley), bounce count and period in samples.
- Raises a lock flag once the stream repeats a stable bounce pattern.
- Sits beside the display/sprite path. Used for on-board self-check and for driving effects synchronised to the bounce (e.g. flash on wall hit).

Parameters:
- COORD_W, 7, coordinate width.
- PERIOD_W, 9, width of sample counter and period output. Holds 2*127+2.
- BOUNCE_W, 8, width of bounce counter. Wraps modulo 2^BOUNCE_W.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  sample strobe; same strobe that advances the generator.
- clear  in  1  synchronous clear; return to IDLE, zero all stats.
- coord  in  COORD_W  coordinate under observation.
- dir  out  1  0 = increasing, 1 = decreasing. Valid only while moving.
- moving  out  1  1 in UP or DOWN state.
- top_pulse  out  1  one-cycle pulse on a peak turn.
- bot_pulse  out  1  one-cycle pulse on a valley turn.
- peak  out  COORD_W  coordinate of the last peak.
- valley  out  COORD_W  coordinate of the last valley.
- bounce_count  out  BOUNCE_W  total turns (peaks + valleys).
- period  out  PERIOD_W  samples between the last two peak turns.
- locked  out  1  stable oscillation detected.

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs 0. prev=0, cnt=0.
- clear=1 has priority over en. Same effect as reset, applied at the next clk edge.
- Only edges with en=1 are samples. With en=0 all state holds and the pulses are 0.
- All outputs are registered. They reflect a sample on the edge that captured it (one-cycle latency from coord valid).
- States:
  - IDLE: first sample stores prev=coord and goes to ACQUIRE.
  - ACQUIRE: coord>prev goes to UP. coord<prev goes to DOWN. Equal stays in ACQUIRE.
  - UP: coord>prev stays in UP. coord<prev is a peak turn.
  - DOWN: coord<prev stays in DOWN. coord>prev is a valley turn.
- Equal samples (hold) never change state; they are normal at generator turning points.
- prev<=coord on every sample.
- Peak turn, taken on the UP-to-DOWN sample:
  - peak<=prev, top_pulse=1, bounce_count++, state DOWN.
  - period<=cnt, cnt<=1.
- Valley turn:
  - valley<=prev, bot_pulse=1, bounce_count++, state UP.
- cnt:
  - Held at 0 until the first peak turn.
  - After that it increments on every non-peak-turn sample and saturates at all-ones.
  - The first peak turn loads period from cnt=0. period=0 means not yet measured.
- locked:
  - On each peak turn, locked<=1 iff cnt==period_old AND prev==peak_old AND period_old!=0. Otherwise locked<=0.
  - Unchanged at valley turns.
- Comparisons are unsigned on COORD_W bits. No wrap between 0 and max is treated as motion continuity; 127→0 is a DOWN step.
- Turn and clear in the same cycle: clear wins, no pulse.

Optional Feature:
- Macro STEP_CHECK_EN.
- Defined:
  - Adds output step_err (1 bit, sticky).
  - A sample with |coord−prev|>1 sets step_err and forces state ACQUIRE.
  - That sample produces no pulse, and locked<=0, cnt<=0, period kept.
  - step_err clears only on reset/clear.
- Undefined: no step_err port. Any delta is accepted as a move.

Test Plan:
- Generator stream L=2, U=5 starting at 2, en every cycle:
  - first peak turn at sample 5 gives peak=5, period=0.
  - second peak turn gives period=8.
  - third gives locked=1.
  - valley=2 throughout.
  - bounce_count increments by 1 per turn.
- Same stream with en asserted 1 of 4 cycles: identical period/peak/valley results. Outputs hold between strobes, pulses last one cycle.
- Bounds changed mid-run L=2, U=5 → L=2, U=9: next period is ≠8 and locked drops to 0. It reasserts after two consecutive period=16 measurements.
- Constant coord=40 for 20 samples: state stays ACQUIRE, moving=0, bounce_count=0.
- reset_n pulsed low asynchronously mid-DOWN: all outputs 0 immediately. clear pulsed mid-UP: same values on the next edge.
- STEP_CHECK_EN: stream 10,11,12,20,21: step_err=1 at sample 20, state ACQUIRE, locked=0. The UP state is reacquired at 21.
